// File: rtl/bus_pkg.sv
//------------------------------------------------------------------------------
// Module : bus_pkg
// Brief  : Shared bus widths, slave register map and address-region decoder.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bus_pkg;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_ADDR_W = 8;

    localparam logic [5:0] RAM_LAST   = 6'h1F;
    localparam logic [5:0] CTRL_ADDR  = 6'h20;
    localparam logic [5:0] WRCNT_ADDR = 6'h21;
    localparam logic [5:0] RDCNT_ADDR = 6'h22;
    localparam logic [5:0] LADDR_ADDR = 6'h23;

    localparam int WP_BIT  = 0;
    localparam int CLR_BIT = 1;

    typedef enum logic [2:0] {
        REG_RAM   = 3'd0,
        REG_CTRL  = 3'd1,
        REG_WRCNT = 3'd2,
        REG_RDCNT = 3'd3,
        REG_LADDR = 3'd4,
        REG_RSVD  = 3'd5
    } region_e;

    function automatic region_e decode_region(input logic [5:0] addr);
        region_e r;
        if (addr <= RAM_LAST)          r = REG_RAM;
        else if (addr == CTRL_ADDR)    r = REG_CTRL;
        else if (addr == WRCNT_ADDR)   r = REG_WRCNT;
        else if (addr == RDCNT_ADDR)   r = REG_RDCNT;
        else if (addr == LADDR_ADDR)   r = REG_LADDR;
        else                           r = REG_RSVD;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module : sat_counter
// Brief  : Saturating up-counter; clear has priority over increment.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/bus_mem_slave.sv
//------------------------------------------------------------------------------
// Module : bus_mem_slave
// Brief  : Bus slave with 32x32 RAM, control/status registers and registered read data.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_mem_slave
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              S_sel,
    input  logic              S_wr,
    input  logic [ADDR_W-1:0] S_address,
    input  logic [DATA_W-1:0] S_din,
    output logic [DATA_W-1:0] S_dout
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic              wp_q;
    logic [ADDR_W-1:0] laddr_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] dout_d;

    logic [DATA_W-1:0] w_wr_cnt;
    logic [DATA_W-1:0] w_rd_cnt;
    region_e           w_region;
    logic [IDX_W-1:0]  w_idx;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ram_wr;
    logic              w_ctrl_wr;
    logic              w_cnt_clr;
    logic              w_ram_rd;

    assign w_region  = decode_region(S_address[5:0]);
    assign w_idx     = S_address[IDX_W-1:0];
    // sel gates every other input so X on an unselected bus never propagates
    assign w_wr_acc  = S_sel && S_wr;
    assign w_rd_acc  = S_sel && !S_wr;
    assign w_ram_wr  = w_wr_acc && (w_region == REG_RAM) && !wp_q;
    assign w_ctrl_wr = w_wr_acc && (w_region == REG_CTRL);
    assign w_cnt_clr = w_ctrl_wr && S_din[CLR_BIT];
    assign w_ram_rd  = w_rd_acc && (w_region == REG_RAM);

    sat_counter #(.WIDTH(DATA_W)) u_wr_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_ram_wr),
        .clr_i   (w_cnt_clr),
        .count_o (w_wr_cnt)
    );

    sat_counter #(.WIDTH(DATA_W)) u_rd_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (w_ram_rd),
        .clr_i   (w_cnt_clr),
        .count_o (w_rd_cnt)
    );

    always_comb begin
        dout_d = '0;
        if (w_rd_acc) begin
            case (w_region)
                REG_RAM:   dout_d = ram_q[w_idx];
                REG_CTRL:  dout_d = {{(DATA_W-1){1'b0}}, wp_q};
                REG_WRCNT: dout_d = w_wr_cnt;
                REG_RDCNT: dout_d = w_rd_cnt;
                REG_LADDR: dout_d = {{(DATA_W-ADDR_W){1'b0}}, laddr_q};
                default:   dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram_q[i] <= '0;
            end
        end else if (w_ram_wr) begin
            ram_q[w_idx] <= S_din;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q    <= 1'b0;
            laddr_q <= '0;
            dout_q  <= '0;
        end else begin
            dout_q <= dout_d;
            if (w_ctrl_wr) begin
                wp_q <= S_din[WP_BIT];
            end
            if (w_ram_wr) begin
                laddr_q <= S_address;
            end
        end
    end

    assign S_dout = dout_q;

endmodule

`default_nettype wire
